// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the NOP filler word, fetch exception cause codes and the PC step.
package fetch_pkg;

    typedef enum logic {
        RUN       = 1'b0,
        TRAP_WAIT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam logic [3:0]  EXC_IADDR_MISALIGN = 4'd0;
    localparam logic [3:0]  EXC_IACCESS_FAULT  = 4'd1;
    localparam logic [63:0] PC_INCR            = 64'd4;

endpackage : fetch_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-entry registered IF/ID slot and
// a two-state FSM that parks fetch after an excepting entry until a redirect.
// Optional build macro FETCH_MISALIGN_CHK_EN raises an instruction-address
// misaligned exception when pc[1:0] != 0 instead of using imem data.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] pc_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
    output logic        id_exc_en,
    output logic [3:0]  id_exc_code,
    output logic [63:0] id_exc_val
);

    fetch_state_t r_state, w_state_nxt;
    logic [63:0]  r_pc, w_pc_nxt;
    logic         r_id_valid, w_id_valid_nxt;
    logic [31:0]  r_id_instr, w_id_instr_nxt;
    logic [63:0]  r_id_pc, w_id_pc_nxt;
    logic         r_id_exc_en, w_id_exc_en_nxt;
    logic [3:0]   r_id_exc_code, w_id_exc_code_nxt;
    logic [63:0]  r_id_exc_val, w_id_exc_val_nxt;

    logic         w_advance;
    logic         w_ent_exc_en;
    logic [3:0]   w_ent_exc_code;
    logic [63:0]  w_ent_exc_val;
    logic [31:0]  w_ent_instr;

    assign w_advance = !r_id_valid || id_ready;

    // Form the candidate slot entry for the current PC from the memory response.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_ent_exc_en   = imem_exc_en;
        w_ent_exc_code = imem_exc_en ? imem_exc_code : 4'd0;
        w_ent_exc_val  = imem_exc_en ? imem_exc_val  : 64'd0;
        w_ent_instr    = imem_exc_en ? NOP_INSTR     : imem_instr;
`ifdef FETCH_MISALIGN_CHK_EN
        if (r_pc[1:0] != 2'b00) begin
            w_ent_exc_en   = 1'b1;
            w_ent_exc_code = EXC_IADDR_MISALIGN;
            w_ent_exc_val  = r_pc;
            w_ent_instr    = NOP_INSTR;
        end
`endif
    end

    // Next-state and next-slot logic; a redirect beats every other event.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_id_valid_nxt    = r_id_valid;
        w_id_instr_nxt    = r_id_instr;
        w_id_pc_nxt       = r_id_pc;
        w_id_exc_en_nxt   = r_id_exc_en;
        w_id_exc_code_nxt = r_id_exc_code;
        w_id_exc_val_nxt  = r_id_exc_val;

        if (redirect_en) begin
            w_state_nxt    = RUN;
            w_pc_nxt       = redirect_pc;
            w_id_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_advance) begin
                        w_id_valid_nxt    = 1'b1;
                        w_id_instr_nxt    = w_ent_instr;
                        w_id_pc_nxt       = r_pc;
                        w_id_exc_en_nxt   = w_ent_exc_en;
                        w_id_exc_code_nxt = w_ent_exc_code;
                        w_id_exc_val_nxt  = w_ent_exc_val;
                        if (w_ent_exc_en) begin
                            w_state_nxt = TRAP_WAIT;
                        end else begin
                            w_pc_nxt = r_pc + PC_INCR;
                        end
                    end
                end
                TRAP_WAIT: begin
                    if (r_id_valid && id_ready) begin
                        w_id_valid_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // State and slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= 64'd0;
            r_id_exc_en   <= 1'b0;
            r_id_exc_code <= 4'd0;
            r_id_exc_val  <= 64'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_id_instr    <= w_id_instr_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_id_exc_en   <= w_id_exc_en_nxt;
            r_id_exc_code <= w_id_exc_code_nxt;
            r_id_exc_val  <= w_id_exc_val_nxt;
        end
    end

    assign pc_addr     = r_pc;
    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_exc_en   = r_id_exc_en;
    assign id_exc_code = r_id_exc_code;
    assign id_exc_val  = r_id_exc_val;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with RESET_PC = 0x1000. The instruction
// memory model returns {16'hC0DE, pc[15:0]} and reports an access fault at
// 0x8000; when not faulting it drives junk on code/val so masking is visible.
module tb_fetch_unit;

    localparam logic [63:0] FAULT_PC = 64'h8000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [63:0] pc_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic        id_exc_en;
    logic [3:0]  id_exc_code;
    logic [63:0] id_exc_val;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.RESET_PC(64'h1000)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_addr       (pc_addr),
        .imem_instr    (imem_instr),
        .imem_exc_en   (imem_exc_en),
        .imem_exc_code (imem_exc_code),
        .imem_exc_val  (imem_exc_val),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_exc_en     (id_exc_en),
        .id_exc_code   (id_exc_code),
        .id_exc_val    (id_exc_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory model.
    always_comb begin
        imem_instr    = {16'hC0DE, pc_addr[15:0]};
        imem_exc_en   = (pc_addr == FAULT_PC);
        imem_exc_code = imem_exc_en ? 4'd1 : 4'hF;
        imem_exc_val  = imem_exc_en ? pc_addr : 64'hDEAD_BEEF;
    end

    typedef struct {
        logic        rst;
        logic        redir;
        logic [63:0] rpc;
        logic        ready;
        logic        chk_slot;
        logic [63:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [63:0] e_idpc;
        logic        e_exc;
        logic [3:0]  e_code;
        logic [63:0] e_val;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rd, input logic [63:0] rp,
                       input logic rdy, input logic cs, input logic [63:0] pc,
                       input logic v, input logic [31:0] ins, input logic [63:0] ipc,
                       input logic ex, input logic [3:0] cd, input logic [63:0] vl);
        vec_t t;
        t.rst = r; t.redir = rd; t.rpc = rp; t.ready = rdy; t.chk_slot = cs;
        t.e_pc = pc; t.e_valid = v; t.e_instr = ins; t.e_idpc = ipc;
        t.e_exc = ex; t.e_code = cd; t.e_val = vl;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [63:0] rp, input logic rdy);
        rst = r; redirect_en = rd; redirect_pc = rp; id_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect_en = 1'b0; redirect_pc = 64'd0; id_ready = 1'b1;

        //   rst rd  rpc                     rdy slot pc                       v  instr          id_pc                    exc code val
        add(1, 0, 64'h0,                  1, 1, 64'h1000,                0, NOP,          64'h0,                  0, 0, 64'h0);    // reset
        add(0, 0, 64'h0,                  1, 1, 64'h1004,                1, 32'hC0DE1000, 64'h1000,               0, 0, 64'h0);    // first load
        add(0, 0, 64'h0,                  1, 1, 64'h1008,                1, 32'hC0DE1004, 64'h1004,               0, 0, 64'h0);
        add(0, 0, 64'h0,                  0, 1, 64'h1008,                1, 32'hC0DE1004, 64'h1004,               0, 0, 64'h0);    // stall x3
        add(0, 0, 64'h0,                  0, 1, 64'h1008,                1, 32'hC0DE1004, 64'h1004,               0, 0, 64'h0);
        add(0, 0, 64'h0,                  0, 1, 64'h1008,                1, 32'hC0DE1004, 64'h1004,               0, 0, 64'h0);
        add(0, 0, 64'h0,                  1, 1, 64'h100C,                1, 32'hC0DE1008, 64'h1008,               0, 0, 64'h0);    // resume
        add(0, 1, 64'h40,                 0, 0, 64'h40,                  0, 0,            0,                      0, 0, 64'h0);    // redirect during stall
        add(0, 0, 64'h0,                  0, 1, 64'h44,                  1, 32'hC0DE0040, 64'h40,                 0, 0, 64'h0);
        add(0, 1, FAULT_PC,               1, 0, FAULT_PC,                0, 0,            0,                      0, 0, 64'h0);
        add(0, 0, 64'h0,                  0, 1, FAULT_PC,                1, NOP,          FAULT_PC,               1, 1, FAULT_PC); // access fault
        add(0, 0, 64'h0,                  0, 1, FAULT_PC,                1, NOP,          FAULT_PC,               1, 1, FAULT_PC); // trap held
        add(0, 0, 64'h0,                  1, 0, FAULT_PC,                0, 0,            0,                      0, 0, 64'h0);    // consumed
        add(0, 0, 64'h0,                  1, 0, FAULT_PC,                0, 0,            0,                      0, 0, 64'h0);    // no reload
        add(0, 1, 64'h2000,               1, 0, 64'h2000,                0, 0,            0,                      0, 0, 64'h0);
        add(0, 0, 64'h0,                  1, 1, 64'h2004,                1, 32'hC0DE2000, 64'h2000,               0, 0, 64'h0);    // back in RUN
        add(0, 1, 64'h42,                 1, 0, 64'h42,                  0, 0,            0,                      0, 0, 64'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        add(0, 0, 64'h0,                  1, 1, 64'h42,                  1, NOP,          64'h42,                 1, 0, 64'h42);   // misaligned trap
`else
        add(0, 0, 64'h0,                  1, 1, 64'h46,                  1, 32'hC0DE0042, 64'h42,                 0, 0, 64'h0);    // low bits ignored
`endif
        add(0, 1, FAULT_PC,               1, 0, FAULT_PC,                0, 0,            0,                      0, 0, 64'h0);
        add(0, 0, 64'h0,                  0, 1, FAULT_PC,                1, NOP,          FAULT_PC,               1, 1, FAULT_PC);
        add(1, 1, 64'h3000,               1, 1, 64'h1000,                0, NOP,          64'h0,                  0, 0, 64'h0);    // rst beats redirect
        add(0, 0, 64'h0,                  1, 1, 64'h1004,                1, 32'hC0DE1000, 64'h1000,               0, 0, 64'h0);
        add(0, 1, 64'hFFFF_FFFF_FFFF_FFFC,1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0,            0,                      0, 0, 64'h0);
        add(0, 0, 64'h0,                  1, 1, 64'h0,                   1, 32'hC0DEFFFC, 64'hFFFF_FFFF_FFFF_FFFC,0, 0, 64'h0);    // pc wraps

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
            check($sformatf("v%0d pc_addr", i),  pc_addr,  vecs[i].e_pc);
            check($sformatf("v%0d id_valid", i), {63'd0, id_valid}, {63'd0, vecs[i].e_valid});
            if (vecs[i].chk_slot) begin
                check($sformatf("v%0d id_instr", i),    {32'd0, id_instr},    {32'd0, vecs[i].e_instr});
                check($sformatf("v%0d id_pc", i),       id_pc,                vecs[i].e_idpc);
                check($sformatf("v%0d id_exc_en", i),   {63'd0, id_exc_en},   {63'd0, vecs[i].e_exc});
                check($sformatf("v%0d id_exc_code", i), {60'd0, id_exc_code}, {60'd0, vecs[i].e_code});
                check($sformatf("v%0d id_exc_val", i),  id_exc_val,           vecs[i].e_val);
            end
        end

        // Long trap wait with the slot never consumed, then a redirect that
        // coincides with consumption.
        step(0, 1, FAULT_PC, 0);
        check("trap redirect pc", pc_addr, FAULT_PC);
        step(0, 0, 64'h0, 0);
        check("trap load exc", {63'd0, id_exc_en}, 64'd1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 64'h0, 0);
            check($sformatf("trap hold%0d pc", k),    pc_addr, FAULT_PC);
            check($sformatf("trap hold%0d valid", k), {63'd0, id_valid}, 64'd1);
            check($sformatf("trap hold%0d code", k),  {60'd0, id_exc_code}, 64'd1);
        end
        step(0, 1, 64'h100, 1);
        check("trap exit pc", pc_addr, 64'h100);
        check("trap exit valid", {63'd0, id_valid}, 64'd0);
        step(0, 0, 64'h0, 1);
        check("post trap id_pc", id_pc, 64'h100);
        check("post trap valid", {63'd0, id_valid}, 64'd1);
        check("post trap exc_en", {63'd0, id_exc_en}, 64'd0);
        check("post trap code", {60'd0, id_exc_code}, 64'd0);
        check("post trap val", id_exc_val, 64'd0);
        check("post trap pc", pc_addr, 64'h104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_0000_0000, PC loaded on reset.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port pc_addr  out  64  fetch address to instruction memory, driven directly from the PC register.
REQ-005 SHALL have port imem_instr  in  32  instruction word returned combinationally for pc_addr.
REQ-006 SHALL have port imem_exc_en  in  1  memory-side fetch exception flag.
REQ-007 SHALL have port imem_exc_code  in  4  memory-side exception cause.
REQ-008 SHALL have port imem_exc_val  in  64  memory-side exception value (faulting PC).
REQ-009 SHALL have port redirect_en  in  1  branch/jump/trap redirect request.
REQ-010 SHALL have port redirect_pc  in  64  redirect target.
REQ-011 SHALL have port id_ready  in  1  decode stage accepts the ID slot this cycle.
REQ-012 SHALL have ports id_valid out 1, id_instr out 32, id_pc out 64, id_exc_en out 1, id_exc_code out 4, id_exc_val out 64: registered IF/ID slot.

Function
REQ-013 SHALL compute advance = !id_valid || id_ready; the slot is consumed when id_valid && id_ready.
REQ-014 In state RUN with advance and no redirect, SHALL load the slot on the clock edge: id_valid=1, id_instr=imem_instr, id_pc=pc, exc fields from imem; and set pc = pc + 4 (64-bit, wraps modulo 2^64).
REQ-015 In state RUN without advance, SHALL hold pc and all id_* outputs unchanged (stall).
REQ-016 When the loaded entry carries an exception (id_exc_en=1 on load), id_instr SHALL be 32'h00000013, pc SHALL NOT increment, and state SHALL become TRAP_WAIT.
REQ-017 In TRAP_WAIT, SHALL hold pc; on consumption of the slot, id_valid SHALL become 0; no new entry SHALL be loaded.
REQ-018 redirect_en SHALL take priority over every other event in either state: next cycle pc=redirect_pc, id_valid=0, state=RUN; a slot offered that cycle is discarded.
REQ-019 Fetch latency SHALL be one cycle: entry for PC p is visible on id_* the cycle after pc_addr=p with advance.
REQ-020 id_exc_code/id_exc_val SHALL be 0 whenever id_exc_en=0.

Reset
REQ-021 On rst: pc=RESET_PC, state=RUN, id_valid=0, id_instr=32'h00000013, id_pc=0, id_exc_en=0, id_exc_code=0, id_exc_val=0.
REQ-022 rst SHALL override redirect_en and any in-flight stall or trap; first load occurs the cycle after rst deasserts.

Configuration
REQ-023 With macro FETCH_MISALIGN_CHK_EN defined, pc[1:0]!=0 SHALL produce an entry with id_exc_en=1, id_exc_code=0 (instruction address misaligned), id_exc_val=pc, id_instr=32'h00000013, ignoring imem inputs, then TRAP_WAIT.
REQ-024 Without FETCH_MISALIGN_CHK_EN, pc[1:0] SHALL be ignored and imem outputs used unchanged.

Structure
REQ-025 Package fetch_pkg SHALL hold the state encoding (RUN, TRAP_WAIT), NOP constant 32'h00000013, exception codes EXC_IADDR_MISALIGN=0, EXC_IACCESS_FAULT=1, and PC increment 4.
REQ-026 SHALL be a single module; no sub-module.

Verification
REQ-027 Reset RESET_PC=0x1000, id_ready=1 -> pc_addr 0x1000,0x1004,0x1008 on successive cycles; id_pc trails by one cycle; id_valid=1 from cycle 2.
REQ-028 id_ready=0 for 3 cycles mid-stream at id_pc=0x1004 -> pc_addr holds 0x1008, id_* stable for 3 cycles, resumes at 0x1008.
REQ-029 imem_exc_en=1, code=1, val=0x8000 at pc 0x8000 -> id_exc_en=1, id_instr=0x00000013, pc holds 0x8000; after consumption id_valid=0 until redirect_en with 0x2000 -> pc_addr=0x2000, RUN.
REQ-030 redirect_en with redirect_pc=0x40 coincident with id_ready=0 -> next cycle id_valid=0, pc_addr=0x40; following cycle id_pc=0x40.
REQ-031 FETCH_MISALIGN_CHK_EN defined, redirect_pc=0x42 -> one cycle later id_exc_en=1, id_exc_code=0, id_exc_val=0x42; undefined -> normal entry with id_pc=0x42.
REQ-032 rst asserted while in TRAP_WAIT with redirect_en=1 -> pc=RESET_PC, id_valid=0, state RUN; redirect ignored.
